// File: rtl/imem_loader_if.sv
// Byte-stream input and instr_mem port B write bundle for imem_loader.
//   in_valid/in_data/in_ready : byte stream, byte taken when in_valid && in_ready
//   imem_we/imem_addr/imem_wdata : instr_mem port B word write
// slave  : the loader (consumes bytes, drives port B)
// master : the environment (byte source, memory side observer)
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image as a byte stream and writes it
// word-by-word into instr_mem port B, holding the core while a load is underway.
// Frame: MAGIC, LEN_LO, LEN_HI, 4*LEN payload bytes (LE words), XOR checksum.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus        : imem_loader_if.slave (byte stream in, port B write out)
//   core_hold  : stall the core while high
//   load_done  : sticky, last frame loaded with good checksum
//   load_err   : sticky, length overflow or checksum mismatch (cleared by rst only)
module imem_loader #(
  parameter int unsigned ADDR_W        = 10,
  parameter logic [7:0]  MAGIC         = 8'hA5,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  state_t            state, state_n;
  logic              acc;
  logic [7:0]        len_lo;
  logic [15:0]       len, len_in;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic [7:0]        csum;
  logic              last_word;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              hold_q, done_q;

  assign bus.in_ready   = ~rst & (state != S_ERR);
  assign acc            = bus.in_valid & bus.in_ready;
  assign len_in         = {bus.in_data, len_lo};
  // DATA is only entered with len >= 1, so len-1 never underflows there.
  assign last_word      = (word_cnt == len - 16'd1);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_hold      = hold_q;
  assign load_done      = done_q;
  assign load_err       = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (acc) begin
      case (state)
        S_IDLE: if (bus.in_data == MAGIC) state_n = S_LEN0;
        S_LEN0: state_n = S_LEN1;
        S_LEN1: begin
          if ({1'b0, len_in} > MAX_LEN) state_n = S_ERR;
          else if (len_in == 16'd0)     state_n = S_CSUM;
          else                          state_n = S_DATA;
        end
        S_DATA: if (byte_cnt == 2'd3 && last_word) state_n = S_CSUM;
        S_CSUM: state_n = (bus.in_data == csum) ? S_IDLE : S_ERR;
        default: state_n = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= HOLD_AT_RESET;
      done_q   <= 1'b0;
      len_lo   <= '0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      csum     <= '0;
    end else begin
      we_q <= 1'b0;
      if (acc) begin
        case (state)
          S_IDLE: begin
            if (bus.in_data == MAGIC) begin
              hold_q   <= 1'b1;
              done_q   <= 1'b0;
              word_cnt <= '0;
              byte_cnt <= '0;
              csum     <= '0;
            end
          end
          S_LEN0: len_lo <= bus.in_data;
          S_LEN1: len    <= len_in;
          S_DATA: begin
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // First byte ends up in bits [7:0] once three bytes have shifted in.
            asm_q    <= {bus.in_data, asm_q[23:8]};
            if (byte_cnt == 2'd3) begin
              we_q     <= 1'b1;
              addr_q   <= word_cnt[ADDR_W-1:0];
              wdata_q  <= {bus.in_data, asm_q};
              word_cnt <= word_cnt + 16'd1;
            end
          end
          S_CSUM: begin
            if (bus.in_data == csum) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (ADDR_W=4 so the full-depth boundary is short).
module tb_imem_loader;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic core_hold, load_done, load_err;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [127:0] b;      // bytes right-aligned, first byte most significant
    int unsigned n;       // byte count
    int unsigned fp;      // index of first payload byte
    logic [31:0] w0, w1;  // expected words at addr 0 and 1
    int unsigned nw;      // words expected to be written
    logic        done, err, hold, ready;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int unsigned   due;
  } wr_t;

  vec_t        vecs[5];
  wr_t         sbq[$];
  int unsigned total = 0, bad = 0, ncyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every observed write must match the next expected one, on the cycle expected.
  always @(negedge clk) begin
    wr_t e;
    ncyc++;
    if (bus.imem_we === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
        check("wr_cycle", ncyc, e.due);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap,
                           input logic push, input logic [AW-1:0] a, input logic [31:0] d);
    wr_t t;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (push) begin
      t.addr = a; t.data = d; t.due = ncyc + 2;
      sbq.push_back(t);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_and_check_pending();
    repeat (3) @(posedge clk);
    #1;
    check("pending_writes", sbq.size(), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input bit gaps);
    logic [7:0]  by;
    int unsigned k;
    logic        push;
    for (int unsigned i = 0; i < v.n; i++) begin
      by   = v.b[8*(v.n-1-i) +: 8];
      push = 1'b0;
      k    = 0;
      if (i >= v.fp && ((i - v.fp) % 4) == 3) begin
        k    = (i - v.fp) / 4;
        push = (k < v.nw);
      end
      send_byte(by, gaps ? $urandom_range(0, 5) : 0, push, k[AW-1:0], (k == 0) ? v.w0 : v.w1);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e,
                             input logic h, input logic r);
    check({tag, "_done"}, 32'(load_done), 32'(d));
    check({tag, "_err"}, 32'(load_err), 32'(e));
    check({tag, "_hold"}, 32'(core_hold), 32'(h));
    check({tag, "_ready"}, 32'(bus.in_ready), 32'(r));
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;

    // Payload 13 00 00 00 93 00 10 00 XORs to 0x90.
    vecs[0] = '{"good2", 128'({8'hA5,8'h02,8'h00, 8'h13,8'h00,8'h00,8'h00,
                8'h93,8'h00,8'h10,8'h00, 8'h90}), 12, 3, 32'h00000013, 32'h00100093, 2,
                1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"badcsum", 128'({8'hA5,8'h02,8'h00, 8'h13,8'h00,8'h00,8'h00,
                8'h93,8'h00,8'h10,8'h00, 8'h84}), 12, 3, 32'h00000013, 32'h00100093, 2,
                1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"junk_len0", 128'({8'h00,8'hFF,8'h5A, 8'hA5,8'h00,8'h00,8'h00}), 7, 6,
                32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"len17", 128'({8'hA5,8'h11,8'h00}), 3, 3, 32'h0, 32'h0, 0,
                1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"len256", 128'({8'hA5,8'h00,8'h01}), 3, 3, 32'h0, 32'h0, 0,
                1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_rst", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b1, 1'b1);

    // Table-driven frames
    for (int unsigned v = 0; v < 5; v++) begin
      do_reset();
      run_vec(vecs[v], 1'b0);
      idle_and_check_pending();
      check_flags(vecs[v].name, vecs[v].done, vecs[v].err, vecs[v].hold, vecs[v].ready);
    end

    // Error is cleared by reset, hold returns to its reset value
    do_reset();
    check_flags("after_err_rst", 1'b0, 1'b0, 1'b1, 1'b1);

    // Random in_valid gaps inside words
    run_vec(vecs[0], 1'b1);
    idle_and_check_pending();
    check_flags("gaps", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reload after load_done: hold reasserts on MAGIC
    send_byte(8'hA5, 0, 1'b0, '0, '0);
    check("reload_hold", 32'(core_hold), 32'd1);
    check("reload_done_clr", 32'(load_done), 32'd0);
    send_byte(8'h01, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    send_byte(8'hEF, 0, 1'b0, '0, '0);
    send_byte(8'hBE, 0, 1'b0, '0, '0);
    send_byte(8'hAD, 0, 1'b0, '0, '0);
    send_byte(8'hDE, 0, 1'b1, '0, 32'hDEADBEEF);
    send_byte(8'h22, 0, 1'b0, '0, '0);
    idle_and_check_pending();
    check_flags("reload", 1'b1, 1'b0, 1'b0, 1'b1);

    // Full depth: LEN = 16, last write at addr 15, no wrap
    do_reset();
    send_byte(8'hA5, 0, 1'b0, '0, '0);
    send_byte(8'h10, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    cs = 8'h00;
    for (int unsigned k = 0; k < 16; k++) begin
      w = $urandom;
      for (int unsigned j = 0; j < 4; j++) begin
        cs = cs ^ w[8*j +: 8];
        send_byte(w[8*j +: 8], $urandom_range(0, 1), (j == 3), k[AW-1:0], w);
      end
    end
    send_byte(cs, 0, 1'b0, '0, '0);
    idle_and_check_pending();
    check("full_last_addr", 32'(bus.imem_addr), 32'd15);
    check_flags("full", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame after 2nd byte of word 1: no write for word 1
    do_reset();
    send_byte(8'hA5, 0, 1'b0, '0, '0);
    send_byte(8'h02, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    send_byte(8'h13, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b1, '0, 32'h00000013);
    send_byte(8'h93, 0, 1'b0, '0, '0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    do_reset();
    idle_and_check_pending();
    check("midrst_addr", 32'(bus.imem_addr), 32'd0);
    check_flags("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
    run_vec(vecs[0], 1'b0);
    idle_and_check_pending();
    check_flags("after_midrst", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
